// File: rtl/periph_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the peripheral decoder.
interface periph_bus_arbiter_if;
   logic        m0_req;
   logic        m0_rw;
   logic [31:0] m0_address;
   logic [31:0] m0_wdata;
   logic        m0_ack;
   logic        m0_err;
   logic [31:0] m0_rdata;

   logic        m1_req;
   logic        m1_rw;
   logic [31:0] m1_address;
   logic [31:0] m1_wdata;
   logic        m1_ack;
   logic        m1_err;
   logic [31:0] m1_rdata;

   logic        bus_ce;
   logic        bus_rw;
   logic [31:0] bus_address;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   // Arbiter view: serves the two masters and drives the downstream bus
   modport slave (
      input  m0_req, m0_rw, m0_address, m0_wdata,
      output m0_ack, m0_err, m0_rdata,
      input  m1_req, m1_rw, m1_address, m1_wdata,
      output m1_ack, m1_err, m1_rdata,
      output bus_ce, bus_rw, bus_address, bus_wdata,
      input  bus_rdata, bus_ready
   );

   // Environment view: masters plus peripheral decoder
   modport master (
      output m0_req, m0_rw, m0_address, m0_wdata,
      input  m0_ack, m0_err, m0_rdata,
      output m1_req, m1_rw, m1_address, m1_wdata,
      input  m1_ack, m1_err, m1_rdata,
      input  bus_ce, bus_rw, bus_address, bus_wdata,
      output bus_rdata, bus_ready
   );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and transfer sequencer for the peripheral bus.
// Every output is a flop; the bus fields are latched at grant time so master
// inputs changing mid-transfer cannot disturb the peripheral.
module periph_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic                 clock,
   input logic                 reset_n,
   periph_bus_arbiter_if.slave bif
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        lastGrant_q, lastGrant_d;
   logic [7:0]  count_q, count_d;
   logic        busCe_q, busCe_d;
   logic        busRw_q, busRw_d;
   logic [31:0] busAddress_q, busAddress_d;
   logic [31:0] busWdata_q, busWdata_d;
   logic        m0Ack_q, m0Ack_d, m1Ack_q, m1Ack_d;
   logic        m0Err_q, m0Err_d, m1Err_q, m1Err_d;
   logic [31:0] m0Rdata_q, m0Rdata_d, m1Rdata_q, m1Rdata_d;

   logic        anyReq;
   logic        winner;
   logic [7:0]  countInc;
   logic        accessDone;
   logic [31:0] respRdata;

   assign anyReq     = bif.m0_req | bif.m1_req;
   // On a tie the master that did not win last time gets the bus
   assign winner     = (bif.m0_req & bif.m1_req) ? ~lastGrant_q : bif.m1_req;
   assign countInc   = count_q + 8'd1;
   assign accessDone = bif.bus_ready | (countInc == TIMEOUT_LAST);
   assign respRdata  = (bif.bus_ready & ~busRw_q) ? bif.bus_rdata : 32'd0;

   // State register, reset drops any transfer in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (anyReq) state_d = ACCESS;
         ACCESS:  if (accessDone) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for grant bookkeeping, latched bus fields and responses
   always_comb begin
      owner_d      = owner_q;
      lastGrant_d  = lastGrant_q;
      count_d      = count_q;
      busCe_d      = 1'b0;
      busRw_d      = busRw_q;
      busAddress_d = busAddress_q;
      busWdata_d   = busWdata_q;
      m0Ack_d      = 1'b0;
      m1Ack_d      = 1'b0;
      m0Err_d      = m0Err_q;
      m1Err_d      = m1Err_q;
      m0Rdata_d    = m0Rdata_q;
      m1Rdata_d    = m1Rdata_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               owner_d      = winner;
               lastGrant_d  = winner;
               count_d      = 8'd0;
               busCe_d      = 1'b1;
               busRw_d      = winner ? bif.m1_rw      : bif.m0_rw;
               busAddress_d = winner ? bif.m1_address : bif.m0_address;
               busWdata_d   = winner ? bif.m1_wdata   : bif.m0_wdata;
            end
         end
         ACCESS: begin
            count_d = countInc;
            if (accessDone) begin
               if (owner_q) begin
                  m1Ack_d   = 1'b1;
                  m1Err_d   = ~bif.bus_ready;
                  m1Rdata_d = respRdata;
               end else begin
                  m0Ack_d   = 1'b1;
                  m0Err_d   = ~bif.bus_ready;
                  m0Rdata_d = respRdata;
               end
            end else begin
               busCe_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         owner_q      <= 1'b0;
         lastGrant_q  <= 1'b1;
         count_q      <= 8'd0;
         busCe_q      <= 1'b0;
         busRw_q      <= 1'b0;
         busAddress_q <= 32'd0;
         busWdata_q   <= 32'd0;
         m0Ack_q      <= 1'b0;
         m1Ack_q      <= 1'b0;
         m0Err_q      <= 1'b0;
         m1Err_q      <= 1'b0;
         m0Rdata_q    <= 32'd0;
         m1Rdata_q    <= 32'd0;
      end else begin
         owner_q      <= owner_d;
         lastGrant_q  <= lastGrant_d;
         count_q      <= count_d;
         busCe_q      <= busCe_d;
         busRw_q      <= busRw_d;
         busAddress_q <= busAddress_d;
         busWdata_q   <= busWdata_d;
         m0Ack_q      <= m0Ack_d;
         m1Ack_q      <= m1Ack_d;
         m0Err_q      <= m0Err_d;
         m1Err_q      <= m1Err_d;
         m0Rdata_q    <= m0Rdata_d;
         m1Rdata_q    <= m1Rdata_d;
      end
   end

   assign bif.bus_ce      = busCe_q;
   assign bif.bus_rw      = busRw_q;
   assign bif.bus_address = busAddress_q;
   assign bif.bus_wdata   = busWdata_q;
   assign bif.m0_ack      = m0Ack_q;
   assign bif.m0_err      = m0Err_q;
   assign bif.m0_rdata    = m0Rdata_q;
   assign bif.m1_ack      = m1Ack_q;
   assign bif.m1_err      = m1Err_q;
   assign bif.m1_rdata    = m1Rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed testbench for the two-master peripheral bus arbiter.
module tb_periph_bus_arbiter;

   logic clock;
   logic reset_n;
   int   total;
   int   bad;

   periph_bus_arbiter_if bif();

   periph_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bif     (bif)
   );

   // Free-running clock, 10 time units per cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input int m, input logic req, input logic rw,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (m == 0) begin
         bif.m0_req = req; bif.m0_rw = rw; bif.m0_address = addr; bif.m0_wdata = wdata;
      end else begin
         bif.m1_req = req; bif.m1_rw = rw; bif.m1_address = addr; bif.m1_wdata = wdata;
      end
   endtask

   function automatic logic getAck(input int m);
      return (m == 0) ? bif.m0_ack : bif.m1_ack;
   endfunction

   // One transfer from master m; peripheral raises ready during ACCESS cycle
   // readyAfter (0 = never). Returns how many cycles bus_ce was seen high.
   task automatic doTransfer(input string tag, input int m, input logic rw,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int readyAfter, input logic [31:0] rdata,
                             input bit scramble, output int ceCycles);
      bit stable, acked, otherAck;
      stable = 1; acked = 0; otherAck = 0; ceCycles = 0;
      applyStimulus(m, 1'b1, rw, addr, wdata);
      bif.bus_rdata = rdata;
      bif.bus_ready = 1'b0;
      for (int i = 0; i < 40 && !acked; i++) begin
         @(negedge clock);
         if (getAck(1 - m)) otherAck = 1;
         if (getAck(m)) begin
            acked = 1;
            applyStimulus(m, 1'b0, rw, addr, wdata);
            bif.bus_ready = 1'b0;
         end else begin
            if (bif.bus_ce) begin
               ceCycles++;
               if (bif.bus_address !== addr || bif.bus_wdata !== wdata || bif.bus_rw !== rw)
                  stable = 0;
               if (scramble && ceCycles == 1)
                  applyStimulus(m, 1'b1, ~rw, 32'h0BAD_0000, ~wdata);
            end
            bif.bus_ready = (readyAfter != 0 && ceCycles == readyAfter);
         end
      end
      checkOutput({tag, " acked"}, 32'(acked), 32'd1);
      checkOutput({tag, " bus fields stable"}, 32'(stable), 32'd1);
      checkOutput({tag, " other ack quiet"}, 32'(otherAck), 32'd0);
      @(negedge clock);
      checkOutput({tag, " ack single pulse"}, 32'(getAck(m)), 32'd0);
   endtask

   int ce;
   int ackOrder[$];
   int bothAck;

   initial begin
      total = 0;
      bad   = 0;
      reset_n = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
      applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
      bif.bus_rdata = 32'd0;
      bif.bus_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("reset bus_ce", 32'(bif.bus_ce), 32'd0);
      checkOutput("reset m0_ack", 32'(bif.m0_ack), 32'd0);
      checkOutput("reset bus_address", bif.bus_address, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Single zero-wait read from m0
      doTransfer("read0", 0, 1'b0, 32'h8000_0100, 32'd0, 1, 32'h1234_5678, 0, ce);
      checkOutput("read0 ce cycles", 32'(ce), 32'd1);
      checkOutput("read0 rdata", bif.m0_rdata, 32'h1234_5678);
      checkOutput("read0 err", 32'(bif.m0_err), 32'd0);

      // m1 read so its rdata is nonzero before the write
      doTransfer("read1", 1, 1'b0, 32'h8000_0200, 32'd0, 1, 32'hA5A5_5A5A, 0, ce);
      checkOutput("read1 rdata", bif.m1_rdata, 32'hA5A5_5A5A);

      // m1 write with three wait cycles
      doTransfer("write1", 1, 1'b1, 32'h8000_0210, 32'hCAFE_F00D, 3, 32'hFFFF_FFFF, 0, ce);
      checkOutput("write1 ce cycles", 32'(ce), 32'd3);
      checkOutput("write1 rdata", bif.m1_rdata, 32'd0);
      checkOutput("write1 err", 32'(bif.m1_err), 32'd0);
      checkOutput("m0 rdata held", bif.m0_rdata, 32'h1234_5678);

      // Timeout with no ready
      doTransfer("tmo", 0, 1'b0, 32'h8000_0300, 32'd0, 0, 32'h7777_7777, 0, ce);
      checkOutput("tmo ce cycles", 32'(ce), 32'd16);
      checkOutput("tmo err", 32'(bif.m0_err), 32'd1);
      checkOutput("tmo rdata", bif.m0_rdata, 32'd0);

      // Ready on the very last cycle beats the timeout
      doTransfer("tmo16", 0, 1'b0, 32'h8000_0304, 32'd0, 16, 32'h0BEE_F000, 0, ce);
      checkOutput("tmo16 ce cycles", 32'(ce), 32'd16);
      checkOutput("tmo16 err", 32'(bif.m0_err), 32'd0);
      checkOutput("tmo16 rdata", bif.m0_rdata, 32'h0BEE_F000);

      // Master inputs change during ACCESS
      doTransfer("stab", 0, 1'b0, 32'h8000_0400, 32'h1111_2222, 3, 32'h4444_5555, 1, ce);
      checkOutput("stab ce cycles", 32'(ce), 32'd3);
      checkOutput("stab rdata", bif.m0_rdata, 32'h4444_5555);

      // Reset in the middle of an ACCESS
      applyStimulus(0, 1'b1, 1'b0, 32'h8000_0500, 32'd0);
      bif.bus_ready = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("midop ce before reset", 32'(bif.bus_ce), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midop ce after reset", 32'(bif.bus_ce), 32'd0);
      checkOutput("midop address after reset", bif.bus_address, 32'd0);
      checkOutput("midop rdata after reset", bif.m0_rdata, 32'd0);
      applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clock);
      checkOutput("midop no ack", 32'(bif.m0_ack), 32'd0);

      // Simultaneous requests after reset, held for several transfers
      applyStimulus(0, 1'b1, 1'b0, 32'h8000_0600, 32'd0);
      applyStimulus(1, 1'b1, 1'b1, 32'h8000_0700, 32'h0000_0011);
      bif.bus_ready = 1'b1;
      bif.bus_rdata = 32'h0000_0042;
      reset_n = 1'b1;
      bothAck = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         if (i == 0) checkOutput("tie first grant address", bif.bus_address, 32'h8000_0600);
         if (bif.m0_ack && bif.m1_ack) bothAck++;
         if (bif.m0_ack) ackOrder.push_back(0);
         if (bif.m1_ack) ackOrder.push_back(1);
      end
      applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
      applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0);
      bif.bus_ready = 1'b0;
      checkOutput("tie ack count", 32'(ackOrder.size()), 32'd5);
      checkOutput("tie both ack", 32'(bothAck), 32'd0);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("tie grant %0d", i),
                     (i < ackOrder.size()) ? 32'(ackOrder[i]) : 32'hFFFF_FFFF, 32'(i % 2));
      checkOutput("tie m1 write rdata", bif.m1_rdata, 32'd0);
      checkOutput("tie m0 read rdata", bif.m0_rdata, 32'h0000_0042);
      repeat (3) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter and sequencer for the memory-mapped peripheral bus. It sits between the MIPS core (master 0) and a second bus master such as a DMA engine (master 1), and the peripheral address decoder. It grants the single downstream bus to one master at a time, round-robin. It holds the transfer stable until the addressed peripheral signals completion, and it returns a one-cycle acknowledge with read data, or an error on timeout.

## Interface
- TIMEOUT_CYCLES, 16: maximum number of ACCESS cycles without bus_ready before the transfer is aborted; legal range 2–255.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- m0_req / m1_req  in  1  transfer request, held high until ack.
- m0_rw / m1_rw  in  1  1 = write, 0 = read.
- m0_address / m1_address  in  32  target address (bit 31 set = peripheral space; passed through unchanged).
- m0_wdata / m1_wdata  in  32  write data.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_err / m1_err  out  1  valid with ack: 1 = timeout.
- m0_rdata / m1_rdata  out  32  read data, valid with ack.
- bus_ce  out  1  downstream chip enable.
- bus_rw  out  1  downstream direction, 1 = write.
- bus_address  out  32  downstream address.
- bus_wdata  out  32  downstream write data.
- bus_rdata  in  32  data from the peripheral decoder.
- bus_ready  in  1  peripheral completion, sampled only in ACCESS.

## Operation
- FSM with three states: IDLE, ACCESS, RESP.
- IDLE:
  - bus_ce=0.
  - If any req is high, pick a winner.
    - Only one requesting: that master wins.
    - Both requesting: the master not granted last wins. The last-grant pointer resets to master 1, so master 0 wins the first tie.
  - Register the winner's rw/address/wdata into the bus_* outputs, record the owner, update the pointer, clear the counter, and go to ACCESS.
- ACCESS:
  - bus_ce=1; bus_rw/address/wdata are held constant (master inputs changing mid-transfer have no effect). The counter increments each cycle.
  - bus_ready=1: capture bus_rdata if read (0 if write), set err=0, go to RESP.
  - Otherwise, counter reaching TIMEOUT_CYCLES: set rdata=0, err=1, go to RESP.
  - bus_ready high in the same cycle as the timeout: ready wins, err=0.
- RESP:
  - bus_ce=0; owner's ack=1 for exactly this cycle, with rdata/err valid. Next state is IDLE.
  - Non-owner ack stays 0 and its req keeps waiting.
- The req/ack handshake:
  - The master deasserts req in the cycle after ack.
  - A req still high in IDLE is a new transaction using the current inputs; back-to-back transfers are legal.
  - A req that drops before ack does not cancel the transfer; the response is still issued.
- m*_rdata and m*_err are held until the next response to the same master.
- bus_ready outside ACCESS is ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE, all outputs 0, counter 0, pointer = master 1. A transfer in flight is dropped with no ack.
- Latency:
  - req sampled high at edge N → bus_ce high during cycle N+1.
  - bus_ready sampled high at edge M → ack high during cycle M+1.
  - Minimum req-to-ack: 3 edges; zero-wait peripheral: bus_ready=1 at the first ACCESS edge.
- Timeout: with no ready, bus_ce stays high for exactly TIMEOUT_CYCLES cycles, then ack+err for one cycle.
- A new grant is possible at the edge ending RESP+IDLE. Each transfer costs ACCESS cycles + 2.
- Arbitration fairness: with both masters continuously requesting, grants alternate 0,1,0,1…
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single read: m0 reads 0x8000_0100, bus_ready=1 on the first ACCESS cycle, bus_rdata=0x1234_5678 → bus_ce high 1 cycle, bus_rw=0, m0_ack 1 cycle later with m0_rdata=0x1234_5678, m0_err=0.
- Write with wait states: m1 writes 0xCAFE_F00D to 0x8000_0210, bus_ready after 3 ACCESS cycles → bus_wdata/address stable for 3 cycles, m1_ack once, m1_rdata=0.
- Tie and round-robin: both masters request at the same edge, held through 4 transfers → grant order 0,1,0,1; each ack pulses exactly once per transfer.
- Timeout: no bus_ready, TIMEOUT_CYCLES=16 → bus_ce high for exactly 16 cycles, then m0_ack=1, m0_err=1, m0_rdata=0. A separate case with bus_ready on cycle 16 → err=0.
- Reset mid-operation: assert reset_n=0 during ACCESS → bus_ce, acks and bus_* go 0 immediately. After release, a simultaneous request is granted to m0 first.
- Input stability: change m0_address during ACCESS → bus_address keeps the originally latched value until RESP.
